// File: rtl/carry_increment_adder.sv
`default_nettype none
// ============================================================================
// Module   : carry_increment_adder
// Brief    : 32-bit carry-increment adder (8 x 4-bit blocks), registered
//            sum/cout; optional signed-overflow output via CIA_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module carry_increment_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
`ifdef CIA_OVERFLOW_EN
    ,
    output logic        ovf
`endif
);

    localparam int C_NBLK = 8;
    localparam int C_BW   = 4;

    logic [C_NBLK:0] w_c;
    logic [31:0]     sum_d;
    logic [31:0]     sum_q;
    logic            cout_d;
    logic            cout_q;

    genvar k, b;
    generate
        for (k = 0; k < C_NBLK; k++) begin : g_blk
            logic [C_BW:0]   w_rc;
            logic [C_BW-1:0] w_s0;

            // Per-block ripple adder built from full-adder cells
            for (b = 0; b < C_BW; b++) begin : g_bit
                logic w_a;
                logic w_b;
                assign w_a           = in1[C_BW*k+b];
                assign w_b           = in2[C_BW*k+b];
                assign w_s0[b]       = w_a ^ w_b ^ w_rc[b];
                assign w_rc[b+1]     = (w_a & w_b) | (w_rc[b] & (w_a ^ w_b));
            end

            if (k == 0) begin : g_ripple
                assign w_rc[0]    = w_c[0];
                assign sum_d[3:0] = w_s0;
                assign w_c[1]     = w_rc[C_BW];
            end else begin : g_incr
                logic [C_BW-1:0] w_t;
                assign w_rc[0] = 1'b0;
                assign w_t[0]  = w_c[k];
                for (b = 1; b < C_BW; b++) begin : g_tchain
                    assign w_t[b] = w_t[b-1] & w_s0[b-1];
                end
                for (b = 0; b < C_BW; b++) begin : g_hsum
                    assign sum_d[C_BW*k+b] = w_s0[b] ^ w_t[b];
                end
                // Incoming carry passes through only when the partial sum is all ones
                assign w_c[k+1] = w_rc[C_BW] | (w_c[k] & (w_s0 == 4'hF));
            end
        end
    endgenerate

    assign w_c[0] = cin;
    assign cout_d = w_c[C_NBLK];

`ifdef CIA_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;
    assign ovf_d = (in1[31] == in2[31]) & (sum_d[31] != in1[31]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= 32'h0;
            cout_q <= 1'b0;
`ifdef CIA_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
`ifdef CIA_OVERFLOW_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef CIA_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_carry_increment_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_carry_increment_adder
// Brief    : Scoreboard bench for carry_increment_adder (honours CIA_OVERFLOW_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_carry_increment_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        cin;
    wire  [31:0] sum;
    wire         cout;
`ifdef CIA_OVERFLOW_EN
    wire         ovf;
`endif

    always #5 clk = ~clk;

    carry_increment_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .sum   (sum),
`ifdef CIA_OVERFLOW_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] bb, input logic ci,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input string nm);
        exp_t e;
        @(negedge clk);
        in1 = a;
        in2 = bb;
        cin = ci;
        e.s = es; e.c = ec; e.o = eo; e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: one result per edge, checked just after the edge
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, "_sum"}, sum, e.s);
            chk({e.name, "_cout"}, {31'b0, cout}, {31'b0, e.c});
`ifdef CIA_OVERFLOW_EN
            chk({e.name, "_ovf"}, {31'b0, ovf}, {31'b0, e.o});
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        in1 = 32'h0; in2 = 32'h0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", sum, 32'h0);
        chk("reset_cout", {31'b0, cout}, 32'h0);
`ifdef CIA_OVERFLOW_EN
        chk("reset_ovf", {31'b0, ovf}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                for (int c = 0; c < 2; c++)
                    drive(i, j, c[0], i + j + c, 1'b0, 1'b0, "sweep");

        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, "ff_ff_c0");
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "ff_ff_c1");
        drive(32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, "ff_0");
        drive(32'h00000000, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, "0_ff");
        drive(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, "ff_0_c1");
        drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "m1_p1");
        drive(32'hFFFFFFF6, 32'h00000005, 1'b0, 32'hFFFFFFFB, 1'b0, 1'b0, "m10_p5");
        drive(32'hFFFFFFF6, 32'hFFFFFFFB, 1'b0, 32'hFFFFFFF1, 1'b1, 1'b0, "m10_m5");
        drive(32'h0000000A, 32'h00000005, 1'b0, 32'h0000000F, 1'b0, 1'b0, "p10_p5");
        drive(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, "zero");
        drive(32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0, 1'b0, "incr_prop");
        drive(32'h89ABCDEF, 32'h76543210, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, "mix_c0");
        drive(32'h89ABCDEF, 32'h76543210, 1'b1, 32'h00000000, 1'b1, 1'b0, "mix_c1");
        drive(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0, "blk_carry");
        drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "ovf_pos");
        drive(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, "ovf_neg");
        drive(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, "pre_rst");

        // Asynchronous reset between edges with a nonzero result held
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in1 = 32'h5; in2 = 32'h6; cin = 1'b0;
        #1;
        chk("async_rst_sum", sum, 32'h0);
        chk("async_rst_cout", {31'b0, cout}, 32'h0);
`ifdef CIA_OVERFLOW_EN
        chk("async_rst_ovf", {31'b0, ovf}, 32'h0);
`endif
        @(posedge clk);
        #2;
        chk("hold_rst_sum", sum, 32'h0);
        begin
            exp_t e;
            @(negedge clk);
            rst_n = 1'b1;
            e.s = 32'd11; e.c = 1'b0; e.o = 1'b0; e.name = "post_rst";
            q.push_back(e);
        end
        drive(32'h00000009, 32'h00000009, 1'b1, 32'd19, 1'b0, 1'b0, "final");

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/carry_increment_adder.md
# carry_increment_adder

32-bit carry-increment adder (CIA) with a registered result. The adder is built from 4-bit ripple blocks. Each block precomputes a carry-in-0 result, and an incrementer chain corrects it when the incoming block carry is 1. It serves as a datapath arithmetic primitive: it adds two 32-bit operands plus a carry-in and delivers a 32-bit sum and a carry-out one clock later.

## Interface
- Parameters: none; width is fixed at 32, block size is fixed at 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in1  input  32  operand A; two's-complement or unsigned, treated identically.
- in2  input  32  operand B.
- cin  input  1  carry-in, weight 1.
- sum  output  32  registered (in1 + in2 + cin) mod 2^32.
- cout  output  1  registered carry out of bit 31.
- ovf  output  1  registered signed overflow; present only when CIA_OVERFLOW_EN is defined.

## Operation
- The datapath is split into 8 blocks of 4 bits each: block k covers bits [4k+3:4k].
- Block 0 is a 4-bit ripple-carry adder fed directly by cin. It produces sum[3:0] and c0.
- Blocks 1..7 each contain a 4-bit ripple-carry adder with carry-in tied to 0. It produces a partial sum s0_k and a partial carry g_k.
- Each of blocks 1..7 also has a 4-bit incrementer chain driven by the previous block carry c_{k-1}.
  - Final block sum = s0_k + c_{k-1}, with no carry beyond 4 bits.
  - Block carry c_k = g_k | (c_{k-1} & (s0_k == 4'hF)).
  - Never form c_k by re-adding the operands.
- cout = c_7.
- The arithmetic is pure modular 32-bit addition. Signedness only affects how results are read: the bit pattern is identical for signed and unsigned operands.
- The combinational result must equal in1 + in2 + cin for all 2^65 input combinations.
- Do not use a behavioral "+" on the full 32-bit word. Only 1-bit full/half-adder cells and the block structure above are allowed, so that the CIA topology is preserved.

## Timing
- Registers update on the rising edge of clk: sum, cout (and ovf) capture the combinational result of the operands present at that edge.
- Latency is 1 cycle. Throughput is one operation per cycle.
- There is no handshake and no enable: every edge loads a new result.
- Inputs are not registered. They must be stable for setup before each edge.
- Reset: while rst_n = 0, sum = 32'h0, cout = 0 and ovf = 0, immediately and independent of clk.
- Reset asserted mid-stream discards the in-flight result.
- The first edge after rst_n deasserts captures the operands present at that edge.
- Critical path is about 4 ripple bits + 7 incrementer carry hops + register setup. No multicycle paths.

## Configuration
- CIA_OVERFLOW_EN defined:
  - Adds output ovf.
  - ovf = (in1[31] == in2[31]) & (sumcomb[31] != in1[31]), where sumcomb is the combinational sum.
  - ovf is registered alongside sum and reset to 0.
- CIA_OVERFLOW_EN undefined: the ovf port and its logic are absent. Behaviour of sum and cout is identical in both builds.

## Test plan
- Exhaustive small sweep: in1 = 0..9, in2 = 0..9, cin = 0/1 -> sum = in1 + in2 + cin one cycle later, cout = 0. Example: 9 + 9 + 1 -> sum 32'd19.
- Carry-through-all-blocks cases:
  - 32'hFFFFFFFF + 32'hFFFFFFFF, cin = 0 -> sum 32'hFFFFFFFE, cout 1.
  - Same operands with cin = 1 -> sum 32'hFFFFFFFF, cout 1.
  - 32'hFFFFFFFF + 0, cin = 0 -> sum 32'hFFFFFFFF, cout 0. Operands swapped -> same result.
- Signed cases:
  - -1 + 1 -> sum 0, cout 1.
  - -10 + 5 -> sum 32'hFFFFFFFB (-5), cout 0.
  - -10 + -5 -> sum 32'hFFFFFFF1 (-15), cout 1.
  - 10 + 5 -> 15, cout 0.
  - 0 + 0 -> 0, cout 0.
- Incrementer propagation: 32'h0000FFFF + 0, cin = 1 -> sum 32'h00010000, cout 0. Exercises the c_{k-1} & (s0_k == F) path across blocks 1..3.
- Reset:
  - Assert rst_n = 0 between edges while sum is nonzero -> sum, cout and ovf go to 0 immediately.
  - Hold reset across an edge -> outputs stay 0.
  - Release reset -> the next edge shows the current operands.
- With CIA_OVERFLOW_EN:
  - 32'h7FFFFFFF + 1 -> sum 32'h80000000, ovf 1, cout 0.
  - 32'h80000000 + 32'h80000000 -> sum 0, ovf 1, cout 1.
  - -10 + -5 -> ovf 0.
